// File: rtl/cpu_axi_master.sv
// Single-outstanding CPU-to-AXI bridge: one single-beat read or write per request,
// with a registered one-cycle completion pulse and error flag.
module cpu_axi_master #(
    parameter logic [3:0] MASTER_ID = 4'd0
) (
    input  logic        ACLK,
    input  logic        ARESETn,

    input  logic        req_valid,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,

    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,

    output logic [3:0]  ARID_M,
    output logic [31:0] ARADDR_M,
    output logic [3:0]  ARLEN_M,
    output logic [2:0]  ARSIZE_M,
    output logic [1:0]  ARBURST_M,
    output logic        ARVALID_M,
    input  logic        ARREADY_M,

    input  logic [3:0]  RID_M,
    input  logic [31:0] RDATA_M,
    input  logic [1:0]  RRESP_M,
    input  logic        RLAST_M,
    input  logic        RVALID_M,
    output logic        RREADY_M,

    output logic [3:0]  AWID_M,
    output logic [31:0] AWADDR_M,
    output logic [3:0]  AWLEN_M,
    output logic [2:0]  AWSIZE_M,
    output logic [1:0]  AWBURST_M,
    output logic        AWVALID_M,
    input  logic        AWREADY_M,

    output logic [31:0] WDATA_M,
    output logic [3:0]  WSTRB_M,
    output logic        WLAST_M,
    output logic        WVALID_M,
    input  logic        WREADY_M,

    input  logic [3:0]  BID_M,
    input  logic [1:0]  BRESP_M,
    input  logic        BVALID_M,
    output logic        BREADY_M
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_AW,
        S_W,
        S_B
    } state_t;

    state_t      state, state_nxt;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic        req_take;
    logic        rd_done;
    logic        wr_done;
    logic        rd_err;
    logic        wr_err;

    assign req_take = (state == S_IDLE) && req_valid;
    assign rd_done  = (state == S_R) && RVALID_M && RLAST_M;
    assign wr_done  = (state == S_B) && BVALID_M;
    assign rd_err   = (RRESP_M != 2'b00) || (RID_M != MASTER_ID);
    assign wr_err   = (BRESP_M != 2'b00) || (BID_M != MASTER_ID);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (req_valid) state_nxt = req_write ? S_AW : S_AR;
            S_AR:   if (ARREADY_M) state_nxt = S_R;
            S_R:    if (RVALID_M && RLAST_M) state_nxt = S_IDLE;
            S_AW:   if (AWREADY_M) state_nxt = S_W;
            S_W:    if (WREADY_M) state_nxt = S_B;
            S_B:    if (BVALID_M) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register so reset drops them at once.
    always_comb begin
        ARVALID_M = 1'b0;
        RREADY_M  = 1'b0;
        AWVALID_M = 1'b0;
        WVALID_M  = 1'b0;
        BREADY_M  = 1'b0;
        case (state)
            S_AR:    ARVALID_M = 1'b1;
            S_R:     RREADY_M  = 1'b1;
            S_AW:    AWVALID_M = 1'b1;
            S_W:     WVALID_M  = 1'b1;
            S_B:     BREADY_M  = 1'b1;
            default: ;
        endcase
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (req_take) begin
            write_q <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            wstrb_q <= req_wstrb;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= rd_done || wr_done;
            if (rd_done) begin
                resp_rdata <= RDATA_M;
            end
            if (rd_done || wr_done) begin
                resp_err <= write_q ? wr_err : rd_err;
            end
        end
    end

    assign ARID_M    = MASTER_ID;
    assign ARADDR_M  = addr_q;
    assign ARLEN_M   = 4'd0;
    assign ARSIZE_M  = 3'b010;
    assign ARBURST_M = 2'b01;

    assign AWID_M    = MASTER_ID;
    assign AWADDR_M  = addr_q;
    assign AWLEN_M   = 4'd0;
    assign AWSIZE_M  = 3'b010;
    assign AWBURST_M = 2'b01;

    assign WDATA_M   = wdata_q;
    assign WSTRB_M   = wstrb_q;
    assign WLAST_M   = WVALID_M;

endmodule

// File: tb/tb_cpu_axi_master.sv
// Directed bench for cpu_axi_master: reads, writes, error responses, back-to-back
// requests, mid-transfer reset and ignored requests while busy.
module tb_cpu_axi_master;

    logic        ACLK;
    logic        ARESETn;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        resp_valid, resp_err, busy;
    logic [31:0] resp_rdata;
    logic [3:0]  ARID_M, ARLEN_M;
    logic [31:0] ARADDR_M;
    logic [2:0]  ARSIZE_M;
    logic [1:0]  ARBURST_M;
    logic        ARVALID_M, ARREADY_M;
    logic [3:0]  RID_M;
    logic [31:0] RDATA_M;
    logic [1:0]  RRESP_M;
    logic        RLAST_M, RVALID_M, RREADY_M;
    logic [3:0]  AWID_M, AWLEN_M;
    logic [31:0] AWADDR_M;
    logic [2:0]  AWSIZE_M;
    logic [1:0]  AWBURST_M;
    logic        AWVALID_M, AWREADY_M;
    logic [31:0] WDATA_M;
    logic [3:0]  WSTRB_M;
    logic        WLAST_M, WVALID_M, WREADY_M;
    logic [3:0]  BID_M;
    logic [1:0]  BRESP_M;
    logic        BVALID_M, BREADY_M;

    int checks   = 0;
    int failures = 0;
    int ar_hs    = 0;
    int aw_hs    = 0;
    int ar0, aw0;

    cpu_axi_master #(.MASTER_ID(4'd5)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy),
        .ARID_M(ARID_M), .ARADDR_M(ARADDR_M), .ARLEN_M(ARLEN_M), .ARSIZE_M(ARSIZE_M),
        .ARBURST_M(ARBURST_M), .ARVALID_M(ARVALID_M), .ARREADY_M(ARREADY_M),
        .RID_M(RID_M), .RDATA_M(RDATA_M), .RRESP_M(RRESP_M), .RLAST_M(RLAST_M),
        .RVALID_M(RVALID_M), .RREADY_M(RREADY_M),
        .AWID_M(AWID_M), .AWADDR_M(AWADDR_M), .AWLEN_M(AWLEN_M), .AWSIZE_M(AWSIZE_M),
        .AWBURST_M(AWBURST_M), .AWVALID_M(AWVALID_M), .AWREADY_M(AWREADY_M),
        .WDATA_M(WDATA_M), .WSTRB_M(WSTRB_M), .WLAST_M(WLAST_M), .WVALID_M(WVALID_M),
        .WREADY_M(WREADY_M),
        .BID_M(BID_M), .BRESP_M(BRESP_M), .BVALID_M(BVALID_M), .BREADY_M(BREADY_M)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    always @(posedge ACLK) begin
        if (ARVALID_M && ARREADY_M) ar_hs <= ar_hs + 1;
        if (AWVALID_M && AWREADY_M) aw_hs <= aw_hs + 1;
    end

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        ARESETn   = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        ARREADY_M = 1'b0; AWREADY_M = 1'b0; WREADY_M = 1'b0;
        RID_M = 4'd5; RDATA_M = '0; RRESP_M = 2'b00; RLAST_M = 1'b0; RVALID_M = 1'b0;
        BID_M = 4'd5; BRESP_M = 2'b00; BVALID_M = 1'b0;

        // reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_valids", {ARVALID_M, RREADY_M, AWVALID_M, WVALID_M, BREADY_M}, 0);
        chk("rst_araddr", ARADDR_M, 0);
        chk("rst_awaddr", AWADDR_M, 0);
        chk("rst_wdata", WDATA_M, 0);
        chk("rst_wstrb", WSTRB_M, 0);
        chk("rst_ar_const", {ARID_M, ARLEN_M, ARSIZE_M, ARBURST_M}, {4'd5, 4'd0, 3'b010, 2'b01});
        chk("rst_aw_const", {AWID_M, AWLEN_M, AWSIZE_M, AWBURST_M}, {4'd5, 4'd0, 3'b010, 2'b01});
        tick();
        ARESETn = 1'b1;
        tick();

        // zero-wait read of 0x10
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0010;
        ARREADY_M = 1'b1; RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = 32'hDEAD_BEEF;
        tick();
        req_valid = 1'b0;
        chk("rd_c1_arvalid", ARVALID_M, 1);
        chk("rd_c1_araddr", ARADDR_M, 32'h0000_0010);
        chk("rd_c1_busy", busy, 1);
        chk("rd_c1_rready", RREADY_M, 0);
        tick();
        chk("rd_c2_rready", RREADY_M, 1);
        chk("rd_c2_arvalid", ARVALID_M, 0);
        chk("rd_c2_resp_valid", resp_valid, 0);
        tick();
        chk("rd_c3_resp_valid", resp_valid, 1);
        chk("rd_c3_rdata", resp_rdata, 32'hDEAD_BEEF);
        chk("rd_c3_err", resp_err, 0);
        chk("rd_c3_busy", busy, 0);
        RVALID_M = 1'b0; RLAST_M = 1'b0; ARREADY_M = 1'b0;
        tick();
        chk("rd_c4_resp_valid", resp_valid, 0);

        // write with AWREADY held low for three cycles
        aw0 = aw_hs;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0020;
        req_wdata = 32'h1234_5678; req_wstrb = 4'b0011;
        WREADY_M = 1'b1;
        tick();
        req_valid = 1'b0; req_wdata = 32'hFFFF_FFFF; req_addr = 32'hFFFF_FFFF;
        chk("wr_aw_valid", AWVALID_M, 1);
        chk("wr_aw_addr", AWADDR_M, 32'h0000_0020);
        chk("wr_aw_no_w", WVALID_M, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("wr_stall_awvalid", AWVALID_M, 1);
            chk("wr_stall_awaddr", AWADDR_M, 32'h0000_0020);
            chk("wr_stall_no_w", WVALID_M, 0);
        end
        AWREADY_M = 1'b1;
        tick();
        AWREADY_M = 1'b0;
        chk("wr_w_valid", WVALID_M, 1);
        chk("wr_w_data", WDATA_M, 32'h1234_5678);
        chk("wr_w_strb", WSTRB_M, 4'b0011);
        chk("wr_w_last", WLAST_M, 1);
        chk("wr_w_awvalid", AWVALID_M, 0);
        tick();
        chk("wr_b_bready", BREADY_M, 1);
        chk("wr_b_wvalid", WVALID_M, 0);
        chk("wr_b_resp_valid", resp_valid, 0);
        BVALID_M = 1'b1; BID_M = 4'd5; BRESP_M = 2'b00;
        tick();
        BVALID_M = 1'b0;
        chk("wr_resp_valid", resp_valid, 1);
        chk("wr_resp_err", resp_err, 0);
        chk("wr_rdata_kept", resp_rdata, 32'hDEAD_BEEF);
        chk("wr_one_aw", aw_hs - aw0, 1);
        tick();

        // read with a discarded non-last beat, then SLVERR on the last beat
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0033;
        ARREADY_M = 1'b1; RVALID_M = 1'b1; RLAST_M = 1'b0; RDATA_M = 32'hAAAA_AAAA;
        tick();
        req_valid = 1'b0;
        chk("rdE_araddr_lsb", ARADDR_M, 32'h0000_0033);
        tick();
        tick();
        chk("rdE_still_r", RREADY_M, 1);
        chk("rdE_no_resp", resp_valid, 0);
        RLAST_M = 1'b1; RDATA_M = 32'hCAFE_F00D; RRESP_M = 2'b10;
        tick();
        chk("rdE_resp_valid", resp_valid, 1);
        chk("rdE_rdata", resp_rdata, 32'hCAFE_F00D);
        chk("rdE_err", resp_err, 1);
        RVALID_M = 1'b0; RLAST_M = 1'b0; RRESP_M = 2'b00;

        // write answered with the wrong BID
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0040;
        req_wdata = 32'h0; req_wstrb = 4'hF;
        AWREADY_M = 1'b1; WREADY_M = 1'b1; BVALID_M = 1'b1; BID_M = 4'd6;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        tick();
        chk("wrE_resp_valid", resp_valid, 1);
        chk("wrE_err", resp_err, 1);
        chk("wrE_rdata_kept", resp_rdata, 32'hCAFE_F00D);
        BVALID_M = 1'b0; BID_M = 4'd5; AWREADY_M = 1'b0;

        // read, then write request accepted in the resp_valid cycle
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0050;
        ARREADY_M = 1'b1; RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = 32'h1111_2222;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("b2b_resp_valid", resp_valid, 1);
        chk("b2b_rdata", resp_rdata, 32'h1111_2222);
        chk("b2b_err_cleared", resp_err, 0);
        RVALID_M = 1'b0; RLAST_M = 1'b0; ARREADY_M = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0060;
        req_wdata = 32'h9876_5432; req_wstrb = 4'b1100;
        tick();
        req_valid = 1'b0;
        chk("b2b_awvalid", AWVALID_M, 1);
        chk("b2b_awaddr", AWADDR_M, 32'h0000_0060);
        chk("b2b_pulse_end", resp_valid, 0);

        // reset while stalled in W
        AWREADY_M = 1'b1; WREADY_M = 1'b0;
        tick();
        AWREADY_M = 1'b0;
        chk("rstW_in_w", WVALID_M, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("rstW_wvalid", WVALID_M, 0);
        chk("rstW_busy", busy, 0);
        chk("rstW_wdata", WDATA_M, 0);
        tick();
        ARESETn = 1'b1;
        tick();
        chk("rstW_no_resp", resp_valid, 0);
        chk("rstW_idle", busy, 0);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0070;
        ARREADY_M = 1'b1; RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = 32'h55AA_55AA;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        chk("rstW_rd_valid", resp_valid, 1);
        chk("rstW_rd_data", resp_rdata, 32'h55AA_55AA);
        chk("rstW_rd_err", resp_err, 0);
        RVALID_M = 1'b0; RLAST_M = 1'b0; ARREADY_M = 1'b0;
        WREADY_M = 1'b1;
        tick();

        // requests while busy are ignored
        ar0 = ar_hs; aw0 = aw_hs;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h0000_0080;
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h0000_0090;
        tick();
        req_valid = 1'b0;
        chk("busy_ar_held", ARVALID_M, 1);
        chk("busy_ar_addr", ARADDR_M, 32'h0000_0080);
        chk("busy_no_aw", AWVALID_M, 0);
        ARREADY_M = 1'b1;
        tick();
        ARREADY_M = 1'b0;
        req_valid = 1'b1;
        RVALID_M = 1'b1; RLAST_M = 1'b1; RDATA_M = 32'h0BAD_F00D;
        tick();
        req_valid = 1'b0;
        RVALID_M = 1'b0; RLAST_M = 1'b0;
        chk("busy_resp_valid", resp_valid, 1);
        chk("busy_rdata", resp_rdata, 32'h0BAD_F00D);
        tick();
        chk("busy_idle_after", busy, 0);
        chk("busy_one_ar", ar_hs - ar0, 1);
        chk("busy_no_aw_hs", aw_hs - aw0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cpu_axi_master.md
CPU_AXI_MASTER -- requirements
Module: cpu_axi_master

Interface
REQ-001 SHALL have parameter MASTER_ID, default 4'd0, the ID driven on ARID_M/AWID_M and expected on RID_M/BID_M.
REQ-002 SHALL have port ACLK, in, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port ARESETn, in, 1, asynchronous active-low reset.
REQ-004 SHALL have CPU request ports: req_valid in 1; req_write in 1 (1=write); req_addr in 32; req_wdata in 32; req_wstrb in 4 (active-high byte enables).
REQ-005 SHALL have CPU response ports: resp_valid out 1 (completion pulse); resp_rdata out 32; resp_err out 1; busy out 1.
REQ-006 SHALL have AR ports: ARID_M out 4, ARADDR_M out 32, ARLEN_M out 4, ARSIZE_M out 3, ARBURST_M out 2, ARVALID_M out 1, ARREADY_M in 1.
REQ-007 SHALL have R ports: RID_M in 4, RDATA_M in 32, RRESP_M in 2, RLAST_M in 1, RVALID_M in 1, RREADY_M out 1.
REQ-008 SHALL have AW ports: AWID_M out 4, AWADDR_M out 32, AWLEN_M out 4, AWSIZE_M out 3, AWBURST_M out 2, AWVALID_M out 1, AWREADY_M in 1.
REQ-009 SHALL have W ports: WDATA_M out 32, WSTRB_M out 4, WLAST_M out 1, WVALID_M out 1, WREADY_M in 1.
REQ-010 SHALL have B ports: BID_M in 4, BRESP_M in 2, BVALID_M in 1, BREADY_M out 1.

Function
REQ-011 SHALL issue single-beat transfers only: ARLEN_M=AWLEN_M=0, ARSIZE_M=AWSIZE_M=3'b010, ARBURST_M=AWBURST_M=2'b01 (INCR), WLAST_M=1 whenever WVALID_M=1.
REQ-012 SHALL implement FSM states IDLE, AR, R, AW, W, B; busy=1 in every state except IDLE.
REQ-013 In IDLE with req_valid=1, SHALL register req_write, req_addr, req_wdata, req_wstrb and move to AW if req_write=1, else AR; req_valid outside IDLE is ignored.
REQ-014 AR: ARVALID_M=1, ARADDR_M=registered address, both held stable until ARVALID_M&ARREADY_M; on that handshake go to R.
REQ-015 R: RREADY_M=1; on RVALID_M&RLAST_M capture RDATA_M into resp_rdata and go to IDLE; beats with RLAST_M=0 are accepted and discarded.
REQ-016 AW: AWVALID_M=1, AWADDR_M stable until AWREADY_M; then go to W; W is never asserted before the AW handshake completes.
REQ-017 W: WVALID_M=1 with registered WDATA_M/WSTRB_M held until WREADY_M; then go to B.
REQ-018 B: BREADY_M=1; on BVALID_M go to IDLE; resp_rdata unchanged on writes.
REQ-019 resp_valid SHALL be a registered 1-cycle pulse in the first IDLE cycle after the R or B completion.
REQ-020 resp_err SHALL be set with resp_valid when the completing RRESP_M/BRESP_M != 2'b00 or RID_M/BID_M != MASTER_ID, else cleared.
REQ-021 A req_valid in the same cycle as resp_valid SHALL be accepted (back-to-back).
REQ-022 Outside their driving state, all VALID/READY outputs SHALL be 0; address/data outputs hold their last registered values.
REQ-023 req_addr SHALL be forwarded unmodified, including bits [1:0].
REQ-024 Zero-wait-state slave latency: read req in cycle 0, AR handshake cycle 1, R handshake cycle 2, resp_valid cycle 3; write resp_valid in cycle 4.

Reset
REQ-025 ARESETn=0 SHALL force IDLE immediately, mid-transaction included, abandoning the transfer without a response.
REQ-026 During reset all VALID/READY outputs, resp_valid, resp_err, busy = 0; resp_rdata, all address/data/strobe registers = 0; constant fields per REQ-011.

Verification
REQ-027 Read 0x0000_0010, zero-wait slave returns 0xDEAD_BEEF, RRESP 0 -> resp_valid cycle 3, resp_rdata 0xDEAD_BEEF, resp_err 0.
REQ-028 Write 0x0000_0020, data 0x1234_5678, wstrb 4'b0011, AWREADY delayed 3 cycles -> AWADDR stable during stall, then WDATA 0x1234_5678, WSTRB 0011, WLAST 1, resp_valid after BVALID, resp_err 0.
REQ-029 Read with RRESP 2'b10, then write with BID=MASTER_ID+1 -> resp_err 1 on both completions.
REQ-030 Read, then write request held on req_valid during the resp_valid cycle -> write accepted that cycle, AWVALID_M next cycle.
REQ-031 Assert ARESETn=0 while in W with WREADY_M=0 -> WVALID_M 0, busy 0 same cycle; next read after release completes normally.
REQ-032 req_valid pulses while busy -> ignored; exactly one AR/AW per accepted request.
